// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the memory-controller request port between the
// instruction-fetch unit and the load/store buffer. Loads and stores win
// arbitration. A saturating starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive LSB grants. Flushed fetches and loads run to
// completion on the controller, but their results are suppressed. One idle
// cycle (GAP) always separates consecutive controller operations.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int IF_DATA_W    = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic                 if_done,
  output logic [IF_DATA_W-1:0] if_data,
  input  logic                 ls_req,
  input  logic                 ls_wr,
  input  logic [ADDR_W-1:0]    ls_addr,
  input  logic [2:0]           ls_len,
  input  logic [DATA_W-1:0]    ls_wdata,
  output logic                 ls_done,
  output logic [DATA_W-1:0]    ls_rdata,
  output logic                 mc_en,
  output logic                 mc_is_ls,
  output logic                 mc_wr,
  output logic [ADDR_W-1:0]    mc_addr,
  output logic [2:0]           mc_len,
  output logic [DATA_W-1:0]    mc_wdata,
  input  logic                 mc_if_done,
  input  logic                 mc_ls_done,
  input  logic [IF_DATA_W-1:0] mc_if_data,
  input  logic [DATA_W-1:0]    mc_ls_rdata
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [SCW-1:0]   starve_cnt_r;
  logic             killed_r;
  logic             kill_s;
  logic             grant_if_s;
  logic             grant_ls_s;
  logic             op_done_s;
  logic             starved_s;

  assign starved_s = (starve_cnt_r == SCW'(STARVE_LIMIT));

  // State register; rdy low freezes the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (rdy) begin
      state_r <= state_s;
    end
  end

  // Next-state, arbitration decision, completion and kill qualification.
  always_comb begin
    state_s    = state_r;
    grant_if_s = 1'b0;
    grant_ls_s = 1'b0;
    op_done_s  = 1'b0;
    kill_s     = killed_r;
    case (state_r)
      IDLE: begin
        if (if_req && (!ls_req || starved_s)) begin
          grant_if_s = 1'b1;
          state_s    = BUSY_IF;
        end else if (ls_req) begin
          grant_ls_s = 1'b1;
          state_s    = BUSY_LS;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_IF: begin
        kill_s = killed_r | flush;
        if (mc_if_done) begin
          op_done_s = 1'b1;
          state_s   = GAP;
        end else begin
          state_s = BUSY_IF;
        end
      end
      BUSY_LS: begin
        // Stores have already been committed to memory; never kill them.
        kill_s = killed_r | (flush & ~mc_wr);
        if (mc_ls_done) begin
          op_done_s = 1'b1;
          state_s   = GAP;
        end else begin
          state_s = BUSY_LS;
        end
      end
      GAP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Kill flag: accumulates flushes during BUSY and clears on entry to GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      killed_r <= 1'b0;
    end else if (rdy) begin
      killed_r <= op_done_s ? 1'b0 : kill_s;
    end
  end

  // Starvation counter: counts LSB grants that overtake a pending fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {SCW{1'b0}};
    end else if (rdy && state_r == IDLE) begin
      if (grant_if_s || !if_req) begin
        starve_cnt_r <= {SCW{1'b0}};
      end else if (grant_ls_s && !starved_s) begin
        starve_cnt_r <= starve_cnt_r + SCW'(1);
      end
    end
  end

  // Controller request fields and requester results, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_en    <= 1'b0;
      mc_is_ls <= 1'b0;
      mc_wr    <= 1'b0;
      mc_addr  <= {ADDR_W{1'b0}};
      mc_len   <= 3'd0;
      mc_wdata <= {DATA_W{1'b0}};
      if_done  <= 1'b0;
      if_data  <= {IF_DATA_W{1'b0}};
      ls_done  <= 1'b0;
      ls_rdata <= {DATA_W{1'b0}};
    end else if (rdy) begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      if (grant_if_s) begin
        mc_en    <= 1'b1;
        mc_is_ls <= 1'b0;
        mc_wr    <= 1'b0;
        mc_addr  <= if_addr;
        mc_len   <= 3'd0;
        mc_wdata <= {DATA_W{1'b0}};
      end else if (grant_ls_s) begin
        mc_en    <= 1'b1;
        mc_is_ls <= 1'b1;
        mc_wr    <= ls_wr;
        mc_addr  <= ls_addr;
        mc_len   <= ls_len;
        mc_wdata <= ls_wdata;
      end else if (op_done_s) begin
        mc_en <= 1'b0;
      end
      if (op_done_s && !kill_s) begin
        if (mc_is_ls) begin
          ls_done <= 1'b1;
          if (!mc_wr) begin
            ls_rdata <= mc_ls_rdata;
          end
        end else begin
          if_done <= 1'b1;
          if_data <= mc_if_data;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter placed in front of the byte-serial memory controller. It shares the single memory-controller request port between the instruction-fetch unit and the load/store buffer. Loads and stores have priority, and a starvation counter bounds how long fetch can wait. Results of speculative operations are discarded on a pipeline flush. The block enforces the controller's one-cycle idle gap between operations, so requesters never see a lost or duplicated request.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, load/store data width
- IF_DATA_W, 64, fetch-line width (8 bytes)
- STARVE_LIMIT, 4, consecutive LSB grants allowed while a fetch is pending before fetch is forced (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; when low all state holds and no new grant is issued
- flush  in  1  misprediction clear, one-cycle pulse
- if_req  in  1  fetch request, level, held until if_done or flush
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  IF_DATA_W  fetched line, registered
- ls_req  in  1  load/store request, level, held until ls_done
- ls_wr  in  1  1 = store
- ls_addr  in  ADDR_W  byte address
- ls_len  in  3  byte count 1, 2 or 4
- ls_wdata  in  DATA_W  store data
- ls_done  out  1  one-cycle pulse: store complete or ls_rdata valid
- ls_rdata  out  DATA_W  load data, registered
- mc_en  out  1  controller request; held from grant through the mc_done cycle
- mc_is_ls  out  1  1 = LSB operation, 0 = fetch
- mc_wr, mc_addr, mc_len, mc_wdata  out  1/ADDR_W/3/DATA_W  latched operation fields
- mc_if_done  in  1  controller fetch-complete pulse
- mc_ls_done  in  1  controller load/store-complete pulse
- mc_if_data  in  IF_DATA_W  controller fetch line
- mc_ls_rdata  in  DATA_W  controller load data

## Operation
- FSM states:
  - IDLE: arbitrate among pending requests.
  - BUSY_IF / BUSY_LS: operation in flight; wait for the controller's done pulse.
  - GAP: one mandatory cycle after any done pulse. mc_en stays 0 and no grant is issued. Return to IDLE.
- Arbitration in IDLE:
  - Only ls_req set: grant LSB.
  - Only if_req set: grant IF.
  - Both set: grant IF if starve_cnt == STARVE_LIMIT, otherwise grant LSB.
- starve_cnt (saturating, width clog2(STARVE_LIMIT+1)):
  - Increments on each LSB grant made while if_req=1.
  - Clears on every IF grant, and whenever if_req=0 in IDLE.
- On grant: latch the address, length and data fields into mc_* registers, drive mc_en=1, set mc_is_ls, and move to BUSY_*. The requester's inputs may change after the grant edge.
- BUSY_IF: on mc_if_done, copy mc_if_data into if_data and pulse if_done, unless the operation has been killed.
- BUSY_LS: on mc_ls_done, copy mc_ls_rdata into ls_rdata (loads only) and pulse ls_done, unless the operation has been killed.
- Flush:
  - An in-flight fetch, or an in-flight load, is marked killed. The controller op runs to completion, then the result and done pulse are suppressed.
  - An in-flight store is never killed.
  - A flush in IDLE/GAP drops nothing. Requesters deassert their req themselves.
  - A flush in the same cycle as a done pulse kills that result.
  - The killed flag clears on entry to GAP.
- mc_* fields are held stable for the whole BUSY state.

## Timing
- All outputs are registered. Reset values: mc_en=0, mc_is_ls=0, mc_wr=0, mc_addr=0, mc_len=0, mc_wdata=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0, starve_cnt=0, state=IDLE, killed=0.
- A request sampled high in IDLE at edge N drives mc_en=1 after edge N.
- Completion: mc_*_done high in cycle M produces the requester's done pulse in cycle M+1 and mc_en=0 in cycle M+1. State is GAP in M+1 and IDLE in M+2.
- Earliest next grant is edge M+2.
- Arbiter overhead per operation: 3 cycles plus controller time.
- rdy=0 freezes the FSM, counters and outputs. Done pulses occurring during rdy=0 are not captured, matching the controller, which also pauses.
- Asynchronous reset mid-operation forces reset values immediately. The controller is reset by the same event.

## Test plan
- Single fetch: if_req, if_addr=0x1000, controller done after 9 cycles with line 0x0807060504030201 → if_done one pulse, if_data=0x0807060504030201, mc_en low in the done+1 cycle, next grant no earlier than done+2.
- Contention: if_req and ls_req continuously high with STARVE_LIMIT=4 → grant sequence LS,LS,LS,LS,IF,LS,… and starve_cnt returns to 0 after the IF grant.
- Flush during load: load addr 0x20 in flight, flush pulse → op completes on the controller, no ls_done, ls_rdata unchanged. A following store to 0x24 is granted after GAP.
- Flush during store: store 0xDEADBEEF len 4 in flight, flush → ls_done still pulses once and the controller sees unchanged mc_wdata.
- Flush coincident with mc_if_done → if_done stays 0 and if_data unchanged.
- Reset/rdy: rdy=0 for 5 cycles mid-BUSY_LS → state and mc_* frozen. Then rst_n low asynchronously mid-operation → all outputs 0 before the next clock edge.
